pmu_key_loader: RTL and testbench

Multi-slot serial key loader for the power management unit: receives an LSB-first serial frame (header plus 128/192/256-bit key) on a single data line, validates the header, and commits the key into one of NUM_SLOTS key registers. It is the parametrised successor to the fixed 256-bit PMU key path, adding variable key length, slot addressing, slot clear, framing errors and a registered daisy-chain output. It sits between the external programming pins and the AES key inputs of the bitstream decryptor.

---
 rtl/pmu_key_loader.sv | 170 +++++++++++++++++
 tb/tb_pmu_key_loader.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pmu_key_loader.sv
// rtl/pmu_key_loader.sv - serial multi-slot key loader: header decode, key staging, atomic slot commit
module pmu_key_loader #(
  parameter int          HEADER_WIDTH  = 32,
  parameter int          MAX_KEY_WIDTH = 256,
  parameter int          NUM_SLOTS     = 4,
  parameter logic [15:0] MAGIC         = 16'hA5C3,
  localparam int         SEL_W         = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     data_i,
  input  logic                     en,
  input  logic [SEL_W-1:0]         key_sel_i,
  output logic [MAX_KEY_WIDTH-1:0] key_o,
  output logic [1:0]               key_len_o,
  output logic [NUM_SLOTS-1:0]     key_valid_o,
  output logic                     pwr_up_en,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic [1:0]               err_code_o,
  output logic                     tdo
);

  localparam int CNT_W = $clog2(MAX_KEY_WIDTH) + 1;
  localparam int HDR_KEEP = 26;

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_HEADER, S_KEY, S_COMMIT, S_DONE, S_ERR} state_t;

  state_t                   state;
  logic [CNT_W-1:0]         cnt;
  logic [HDR_KEEP-1:0]      hdr;
  logic [MAX_KEY_WIDTH-1:0] staging;
  logic [7:0]               slot_q;
  logic [1:0]               code_q;
  logic [MAX_KEY_WIDTH-1:0] slots [NUM_SLOTS];
  logic [1:0]               lens  [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]     valid;

  logic hdr_last, key_last, magic_ok, slot_ok;

  // Reserved header bits [31:26] (including the final bit) never affect decode, so only 26 are kept.
  assign hdr_last = (cnt == CNT_W'(HEADER_WIDTH - 1));
  assign magic_ok = (hdr[15:0] == MAGIC);
  assign slot_ok  = ({1'b0, hdr[23:16]} < 9'(NUM_SLOTS));

  always_comb begin
    key_last = 1'b0;
    case (code_q)
      2'd0:    key_last = (cnt == CNT_W'(127));
      2'd1:    key_last = (cnt == CNT_W'(191));
      default: key_last = (cnt == CNT_W'(255));
    endcase
  end

  assign key_valid_o = valid;
  assign busy_o = (state == S_ARM) || (state == S_HEADER) || (state == S_KEY) || (state == S_COMMIT);

  always_comb begin
    key_o     = '0;
    key_len_o = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (key_sel_i == SEL_W'(i)) begin
        key_o     = slots[i];
        key_len_o = lens[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      hdr        <= '0;
      staging    <= '0;
      slot_q     <= '0;
      code_q     <= '0;
      valid      <= '0;
      pwr_up_en  <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      err_code_o <= 2'd0;
      tdo        <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slots[i] <= '0;
        lens[i]  <= '0;
      end
    end else begin
      done_o    <= 1'b0;
      err_o     <= 1'b0;
      tdo       <= en & data_i;
      pwr_up_en <= valid[0];
      case (state)
        S_IDLE: begin
          if (en) begin
            state   <= S_ARM;
            cnt     <= '0;
            hdr     <= '0;
            staging <= '0;
          end
        end
        S_ARM, S_HEADER: begin
          if (!en) begin
            state      <= S_IDLE;
            err_o      <= 1'b1;
            err_code_o <= 2'd3;
          end else if (state == S_ARM) begin
            hdr   <= HDR_KEEP'(data_i);
            cnt   <= CNT_W'(1);
            state <= S_HEADER;
          end else begin
            if (cnt < CNT_W'(HDR_KEEP))
              hdr <= hdr | (HDR_KEEP'(data_i) << cnt[4:0]);
            cnt <= cnt + 1'b1;
            if (hdr_last) begin
              if (!magic_ok) begin
                state      <= S_ERR;
                err_o      <= 1'b1;
                err_code_o <= 2'd1;
              end else if (!slot_ok) begin
                state      <= S_ERR;
                err_o      <= 1'b1;
                err_code_o <= 2'd2;
              end else begin
                slot_q <= hdr[23:16];
                code_q <= hdr[25:24];
                cnt    <= '0;
                state  <= (hdr[25:24] == 2'd3) ? S_COMMIT : S_KEY;
              end
            end
          end
        end
        S_KEY: begin
          if (!en) begin
            state      <= S_IDLE;
            err_o      <= 1'b1;
            err_code_o <= 2'd3;
          end else begin
            staging[cnt[CNT_W-2:0]] <= data_i;
            cnt <= cnt + 1'b1;
            if (key_last) state <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          // Whole-slot write in one cycle; a dropped en here cannot leave a partial key.
          for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slot_q == 8'(i)) begin
              if (code_q == 2'd3) begin
                slots[i] <= '0;
                lens[i]  <= '0;
                valid[i] <= 1'b0;
              end else begin
                slots[i] <= staging;
                lens[i]  <= code_q;
                valid[i] <= 1'b1;
              end
            end
          end
          done_o <= 1'b1;
          state  <= S_DONE;
        end
        S_DONE, S_ERR: begin
          if (!en) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pmu_key_loader.sv
// tb/tb_pmu_key_loader.sv - randomized frames against a frame-level reference model of the key loader
module tb_pmu_key_loader;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         data_i = 1'b0;
  logic         en = 1'b0;
  logic [1:0]   key_sel_i = 2'd0;
  logic [255:0] key_o;
  logic [1:0]   key_len_o;
  logic [3:0]   key_valid_o;
  logic         pwr_up_en, busy_o, done_o, err_o, tdo;
  logic [1:0]   err_code_o;

  pmu_key_loader dut (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .en(en), .key_sel_i(key_sel_i),
    .key_o(key_o), .key_len_o(key_len_o), .key_valid_o(key_valid_o),
    .pwr_up_en(pwr_up_en), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .err_code_o(err_code_o), .tdo(tdo)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [255:0] m_key [4];
  logic [1:0]   m_len [4];
  logic [3:0]   m_valid;
  logic [1:0]   m_err;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 4; s++) begin
      m_key[s] = '0;
      m_len[s] = '0;
    end
    m_valid = '0;
    m_err   = '0;
  endtask

  task automatic check_state(input string tag);
    for (int s = 0; s < 4; s++) begin
      key_sel_i = 2'(s);
      #1;
      chk({tag, "_key"}, key_o, m_key[s]);
      chk({tag, "_len"}, 256'(key_len_o), 256'(m_len[s]));
    end
    chk({tag, "_valid"}, 256'(key_valid_o), 256'(m_valid));
    chk({tag, "_pwr"}, 256'(pwr_up_en), 256'(m_valid[0]));
    chk({tag, "_ecode"}, 256'(err_code_o), 256'(m_err));
    chk({tag, "_busy"}, 256'(busy_o), 256'(0));
  endtask

  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    en    = 1'b0;
    #2;
    model_reset();
    chk({tag, "_done"}, 256'(done_o), 256'(0));
    chk({tag, "_err"}, 256'(err_o), 256'(0));
    chk({tag, "_tdo"}, 256'(tdo), 256'(0));
    check_state(tag);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Expected outcome is derived from frame length alone: 1 arm cycle, 32 header bits, K key bits, 1 commit.
  task automatic run_frame(input string tag, input logic [31:0] hdr, input logic [255:0] key, input int n_en);
    int k_bits, ev_edge, last, done_cnt, err_cnt, seen;
    bit ev_done, d;
    logic [1:0] ecode;
    logic [255:0] mask;
    logic [7:0] slot;
    slot = hdr[23:16];
    k_bits = (hdr[25:24] == 2'd0) ? 128 : (hdr[25:24] == 2'd1) ? 192 : (hdr[25:24] == 2'd2) ? 256 : 0;
    ev_done = 1'b0;
    ecode = 2'd0;
    if (n_en <= 32) begin ev_edge = n_en; ecode = 2'd3; end
    else if (hdr[15:0] != 16'hA5C3) begin ev_edge = 32; ecode = 2'd1; end
    else if (slot >= 8'd4) begin ev_edge = 32; ecode = 2'd2; end
    else if (n_en <= 32 + k_bits) begin ev_edge = n_en; ecode = 2'd3; end
    else begin ev_edge = 33 + k_bits; ev_done = 1'b1; end
    last = ((n_en > ev_edge) ? n_en : ev_edge) + 3;
    done_cnt = 0; err_cnt = 0; seen = -1;
    @(posedge clk);
    #1;
    for (int k = 0; k <= last; k++) begin
      if (k == 0) d = 1'($urandom);
      else if (k <= 32) d = hdr[k-1];
      else if (k - 33 < 256) d = key[k-33];
      else d = 1'($urandom);
      en = (k < n_en);
      data_i = en ? d : 1'($urandom);
      @(posedge clk);
      #1;
      chk({tag, "_tdo"}, 256'(tdo), 256'(en & data_i));
      if (done_o) begin done_cnt++; if (seen < 0) seen = k; end
      if (err_o)  begin err_cnt++;  if (seen < 0) seen = k; end
    end
    en = 1'b0;
    chk({tag, "_ndone"}, 256'(done_cnt), 256'(ev_done ? 1 : 0));
    chk({tag, "_nerr"}, 256'(err_cnt), 256'(ev_done ? 0 : 1));
    chk({tag, "_edge"}, 256'(seen), 256'(ev_edge));
    if (ev_done) begin
      if (k_bits == 0) begin
        m_key[slot[1:0]] = '0;
        m_len[slot[1:0]] = '0;
        m_valid[slot[1:0]] = 1'b0;
      end else begin
        mask = (k_bits == 256) ? '1 : ((256'(1) << k_bits) - 256'(1));
        m_key[slot[1:0]] = key & mask;
        m_len[slot[1:0]] = hdr[25:24];
        m_valid[slot[1:0]] = 1'b1;
      end
    end else begin
      m_err = ecode;
    end
    check_state(tag);
  endtask

  function automatic logic [31:0] mk_hdr(input logic [15:0] magic, input logic [7:0] slot, input logic [1:0] code);
    return {6'($urandom), code, slot, magic};
  endfunction

  function automatic logic [255:0] rnd_key();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  initial begin
    logic [255:0] pat;
    logic [15:0] mg;
    logic [1:0] code;
    int kb, n;
    pat = {4{64'h0123456789ABCDEF}};
    apply_reset("reset");

    run_frame("load256", mk_hdr(16'hA5C3, 8'd0, 2'd2), pat, 289);
    run_frame("load128", mk_hdr(16'hA5C3, 8'd2, 2'd0), rnd_key(), 300);
    run_frame("badmagic", mk_hdr(16'hA5C2, 8'd1, 2'd0), rnd_key(), 40);
    run_frame("badslot", mk_hdr(16'hA5C3, 8'd5, 2'd0), rnd_key(), 200);
    run_frame("abort", mk_hdr(16'hA5C3, 8'd0, 2'd2), rnd_key(), 133);
    run_frame("abort_arm", mk_hdr(16'hA5C3, 8'd1, 2'd2), rnd_key(), 1);
    run_frame("clear", mk_hdr(16'hA5C3, 8'd0, 2'd3), rnd_key(), 33);
    run_frame("load192", mk_hdr(16'hA5C3, 8'd3, 2'd1), rnd_key(), 230);

    pat = rnd_key();
    for (int k = 0; k < 120; k++) begin
      en = 1'b1;
      data_i = (k == 0) ? 1'b0 : (k <= 32) ? mk_hdr(16'hA5C3, 8'd1, 2'd2)[k-1] : pat[k-33];
      @(posedge clk);
      #1;
    end
    apply_reset("midreset");

    for (int t = 0; t < 30; t++) begin
      mg = ($urandom_range(0, 9) == 0) ? (16'hA5C3 ^ (16'h1 << $urandom_range(0, 15))) : 16'hA5C3;
      code = 2'($urandom_range(0, 3));
      kb = (code == 2'd0) ? 128 : (code == 2'd1) ? 192 : (code == 2'd2) ? 256 : 0;
      n = ($urandom_range(0, 9) < 7) ? 33 + kb + $urandom_range(0, 20) : $urandom_range(1, 32 + kb);
      run_frame($sformatf("rnd%0d", t), mk_hdr(mg, 8'($urandom_range(0, 5)), code), rnd_key(), n);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
